track_view_multi: RTL and testbench

Pipelined tile-map track renderer for N karts: maps the VGA raster position (hcount_in/vcount_in) into world coordinates around a camera centred on a selected kart, fetches the track tile from an external 2-cycle block-RAM track map, overlays kart sprites, and emits a 12-bit RGB pixel. It is the generalised successor of the two-kart track_view: kart count, coordinate width and tile size are parameters, and it adds a selectable camera, world wrap-around and frame-synchronous position latching. It sits between the video timing generator and the pixel mux feeding the HDMI/VGA output.

---
 rtl/track_view_multi.sv | 161 ++++++++++++++++
 tb/tb_track_view_multi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/track_view_multi.sv
// Tile-map track renderer for NUM_KARTS karts. Camera follows a selected kart,
// world coordinates wrap modulo 2^COORD_W, kart positions are latched once per
// frame at the start of vblank. Four-cycle fixed latency from raster to pixel.

// Per-kart sprite hit test on a single world coordinate pair.
module track_view_kart_hit #(
  parameter int COORD_W   = 11,
  parameter int KART_HALF = 8
) (
  input  logic [COORD_W-1:0] wx_i,
  input  logic [COORD_W-1:0] wy_i,
  input  logic [COORD_W-1:0] kx_i,
  input  logic [COORD_W-1:0] ky_i,
  output logic               hit_o
);
  logic [COORD_W-1:0] dx, dy;

  // Offset by KART_HALF so the sprite box becomes a single unsigned compare;
  // modulo arithmetic makes the box wrap across the world edge for free.
  always_comb begin
    dx    = wx_i - kx_i + COORD_W'(KART_HALF);
    dy    = wy_i - ky_i + COORD_W'(KART_HALF);
    hit_o = (dx < COORD_W'(2*KART_HALF)) && (dy < COORD_W'(2*KART_HALF));
  end
endmodule

module track_view_multi #(
  parameter int NUM_KARTS = 2,
  parameter int COORD_W   = 11,
  parameter int TILE_LOG2 = 5,
  parameter int KART_HALF = 8,
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [10:0]                         hcount_in,
  input  logic [9:0]                          vcount_in,
  input  logic [2:0]                          cam_sel_in,
  input  logic [NUM_KARTS*COORD_W-1:0]        kart_x_in,
  input  logic [NUM_KARTS*COORD_W-1:0]        kart_y_in,
  output logic [2*(COORD_W-TILE_LOG2)-1:0]    track_addr_out,
  input  logic [1:0]                          track_data_in,
  output logic [11:0]                         pixel_out
);
  localparam int STAGES = 2;

  logic [NUM_KARTS-1:0][COORD_W-1:0] kx_q, ky_q;
  logic [2:0]                        cam_q;
  logic                              latch;
  logic [COORD_W-1:0]                cam_x, cam_y;
  logic [COORD_W-1:0]                wx_d, wy_d, wx1_q, wy1_q;
  logic                              act_d;
  logic [STAGES:0]                   vld_pipe;
  logic [NUM_KARTS-1:0]              hit_c, hit2_q, hit3_q;
  logic                              chk2_q, chk3_q;
  logic [11:0]                       pix_d;

  function automatic logic [11:0] kart_col(input int k);
    case (k)
      0:       return 12'hF00;
      1:       return 12'h00F;
      2:       return 12'h0F0;
      default: return 12'hFF0;
    endcase
  endfunction

  // Start of vblank is always an inactive pixel, so latching here cannot
  // change the camera under an in-flight visible pixel.
  assign latch = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

  // Frame-synchronous copy of kart positions and camera select.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      kx_q  <= '0;
      ky_q  <= '0;
      cam_q <= '0;
    end else if (latch) begin
      kx_q  <= kart_x_in;
      ky_q  <= kart_y_in;
      cam_q <= cam_sel_in;
    end
  end

  // Camera kart; out-of-range selects fall back to kart 0.
  always_comb begin
    cam_x = kx_q[0];
    cam_y = ky_q[0];
    for (int k = 1; k < NUM_KARTS; k++)
      if (int'(cam_q) == k) begin
        cam_x = kx_q[k];
        cam_y = ky_q[k];
      end
  end

  // Raster to world mapping, truncated so the world wraps.
  always_comb begin
    wx_d  = cam_x - COORD_W'(H_ACTIVE/2) + COORD_W'(hcount_in);
    wy_d  = cam_y - COORD_W'(V_ACTIVE/2) + COORD_W'(vcount_in);
    act_d = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
  end

  genvar g;
  generate
    for (g = 0; g < NUM_KARTS; g++) begin : g_kart
      track_view_kart_hit #(.COORD_W(COORD_W), .KART_HALF(KART_HALF)) u_hit (
        .wx_i  (wx1_q),
        .wy_i  (wy1_q),
        .kx_i  (kx_q[g]),
        .ky_i  (ky_q[g]),
        .hit_o (hit_c[g])
      );
    end
  endgenerate

  // Pipeline: stage 1 address/world coords, stage 2 hit test, stage 3 wait
  // for the 2-cycle track RAM.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe       <= '0;
      wx1_q          <= '0;
      wy1_q          <= '0;
      track_addr_out <= '0;
      hit2_q         <= '0;
      chk2_q         <= 1'b0;
      hit3_q         <= '0;
      chk3_q         <= 1'b0;
    end else begin
      vld_pipe       <= {vld_pipe[STAGES-1:0], act_d};
      wx1_q          <= wx_d;
      wy1_q          <= wy_d;
      track_addr_out <= {wy_d[COORD_W-1:TILE_LOG2], wx_d[COORD_W-1:TILE_LOG2]};
      hit2_q         <= hit_c;
      chk2_q         <= wx1_q[2] ^ wy1_q[2];
      hit3_q         <= hit2_q;
      chk3_q         <= chk2_q;
    end
  end

  // Colour select: tile first, karts overwrite from highest index down so the
  // lowest-index kart ends up on top.
  always_comb begin
    pix_d = 12'h000;
    if (vld_pipe[STAGES]) begin
      case (track_data_in)
        2'd0:    pix_d = 12'h0A0;
        2'd1:    pix_d = 12'h888;
        2'd2:    pix_d = 12'hA52;
        default: pix_d = chk3_q ? 12'hFFF : 12'h000;
      endcase
      for (int k = NUM_KARTS-1; k >= 0; k--)
        if (hit3_q[k]) pix_d = kart_col(k);
    end
  end

  // Output pixel register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pixel_out <= 12'h000;
    else           pixel_out <= pix_d;
  end
endmodule

// File: tb/tb_track_view_multi.sv
// Directed bench for track_view_multi with a 2-cycle track RAM model.
module tb_track_view_multi;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h;
  logic [9:0]  v;
  logic [2:0]  cam_sel;
  logic [21:0] kart_x, kart_y;
  logic [11:0] track_addr;
  logic [1:0]  track_data;
  logic [11:0] pixel;

  int total = 0;
  int bad   = 0;

  // mode[2]=1: tile = tile_x[1:0]; else tile = mode[1:0]
  logic [2:0] tile_mode = 3'd1;
  logic [1:0] bram_d1;
  logic [11:0] p, a;

  always #5 clk = ~clk;

  track_view_multi dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .hcount_in      (h),
    .vcount_in      (v),
    .cam_sel_in     (cam_sel),
    .kart_x_in      (kart_x),
    .kart_y_in      (kart_y),
    .track_addr_out (track_addr),
    .track_data_in  (track_data),
    .pixel_out      (pixel)
  );

  always @(posedge clk) begin
    bram_d1    <= tile_mode[2] ? track_addr[1:0] : tile_mode[1:0];
    track_data <= bram_d1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic latch_pos(input logic [10:0] x0, y0, x1, y1, input logic [2:0] cs);
    kart_x  = {x1, x0};
    kart_y  = {y1, y0};
    cam_sel = cs;
    h = 11'd0; v = 10'd720;
    tick;
    h = 11'd1300; v = 10'd100;
  endtask

  // One isolated active pixel; returns its address (1 cycle) and pixel (4 cycles).
  task automatic pix(input logic [10:0] hh, input logic [9:0] vv,
                     output logic [11:0] po, output logic [11:0] ao);
    h = hh; v = vv;
    tick;
    ao = track_addr;
    h = 11'd1300;
    tick; tick; tick;
    po = pixel;
  endtask

  initial begin
    rst_n = 1'b0; h = 11'd100; v = 10'd100; cam_sel = 3'd0;
    kart_x = '0; kart_y = '0;
    tick; tick;
    chk("rst_pix", 16'(pixel), 16'h000);
    chk("rst_addr", 16'(track_addr), 16'h000);
    rst_n = 1'b1;

    // latency: karts far away, road everywhere
    latch_pos(11'd1000, 11'd1000, 11'd1000, 11'd1000, 3'd0);
    tick; tick; tick; tick;
    h = 11'd100;
    tick;
    h = 11'd1300;
    tick; tick;
    chk("lat_n3", 16'(pixel), 16'h000);
    tick;
    chk("lat_n4", 16'(pixel), 16'h888);
    tick;
    chk("lat_inact", 16'(pixel), 16'h000);

    // async reset mid-raster
    h = 11'd100; v = 10'd100;
    tick; tick; tick; tick; tick;
    chk("pre_rst_pix", 16'(pixel), 16'h888);
    chk("pre_rst_addr", 16'(track_addr), 16'h5CE);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pix", 16'(pixel), 16'h000);
    chk("arst_addr", 16'(track_addr), 16'h000);
    tick; tick;
    chk("arst_hold", 16'(pixel), 16'h000);
    rst_n = 1'b1;
    h = 11'd1300;
    tick;
    pix(11'd640, 10'd360, p, a);
    chk("post_rst_kart00", 16'(p), 16'hF00);

    // camera / address / sprite edges
    latch_pos(11'd960, 11'd960, 11'd100, 11'd100, 3'd0);
    pix(11'd640, 10'd360, p, a);
    chk("cam_addr", 16'(a), 16'h79E);
    chk("cam_centre", 16'(p), 16'hF00);
    pix(11'd648, 10'd360, p, a);
    chk("edge_x_out", 16'(p), 16'h888);
    pix(11'd632, 10'd360, p, a);
    chk("edge_x_in", 16'(p), 16'hF00);
    pix(11'd640, 10'd368, p, a);
    chk("edge_y_out", 16'(p), 16'h888);

    // frame latch: new kart 1 position invisible until vblank
    kart_x = {11'd1000, 11'd960};
    kart_y = {11'd960, 11'd960};
    pix(11'd680, 10'd360, p, a);
    chk("latch_before", 16'(p), 16'h888);
    h = 11'd0; v = 10'd720;
    tick;
    pix(11'd680, 10'd360, p, a);
    chk("latch_after", 16'(p), 16'h00F);

    // overlap and wrap, camera on kart 1
    latch_pos(11'd0, 11'd0, 11'd0, 11'd0, 3'd1);
    pix(11'd640, 10'd360, p, a);
    chk("overlap_pri", 16'(p), 16'hF00);
    chk("overlap_addr", 16'(a), 16'h000);
    pix(11'd636, 10'd360, p, a);
    chk("wrap_2044", 16'(p), 16'hF00);
    chk("wrap_addr", 16'(a), 16'h03F);
    pix(11'd632, 10'd360, p, a);
    chk("wrap_2040", 16'(p), 16'hF00);
    pix(11'd631, 10'd360, p, a);
    chk("wrap_2039", 16'(p), 16'h888);

    // tile types and bad cam_sel
    tile_mode = 3'd4;
    latch_pos(11'd960, 11'd960, 11'd200, 11'd200, 3'd7);
    pix(11'd640, 10'd360, p, a);
    chk("badcam_addr", 16'(a), 16'h79E);
    chk("badcam_pix", 16'(p), 16'hF00);
    pix(11'd80, 10'd100, p, a);
    chk("tile_grass", 16'(p), 16'h0A0);
    pix(11'd100, 10'd100, p, a);
    chk("tile_road", 16'(p), 16'h888);
    pix(11'd132, 10'd100, p, a);
    chk("tile_wall", 16'(p), 16'hA52);
    tile_mode = 3'd3;
    pix(11'd100, 10'd100, p, a);
    chk("chk_100", 16'(p), 16'h000);
    pix(11'd104, 10'd100, p, a);
    chk("chk_104", 16'(p), 16'hFFF);
    pix(11'd108, 10'd100, p, a);
    chk("chk_108", 16'(p), 16'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
